// File: rtl/lsu_ctrl_pkg.sv
// Shared constants and types for the load/store unit controller.
// Access-width encodings match the decoder's LoadStoreWidth field.
package lsu_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] LSW_BYTE = 2'b00;
  localparam logic [1:0] LSW_HALF = 2'b01;
  localparam logic [1:0] LSW_WORD = 2'b10;

  // Everything about an accepted access that must survive until DONE.
  typedef struct packed {
    logic       is_load;
    logic       uns;
    logic [1:0] width;
    logic [1:0] addr_lo;
    logic [4:0] rd;
    logic       err;
  } lsu_req_t;

  // Width 11 is treated as an alignment fault so it shares the reject path.
  function automatic logic lsu_misaligned(input logic [1:0] width,
                                          input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (width)
      LSW_BYTE: bad = 1'b0;
      LSW_HALF: bad = addr_lo[0];
      LSW_WORD: bad = (addr_lo != 2'b00);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication, byte enables, load
// extraction with sign/zero extension, and the alignment check.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic            is_load,
  input  logic [1:0]      width,
  input  logic [1:0]      addr_lo,
  input  logic            uns,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      byte_en,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    wdata      = store_data;
    byte_en    = 4'b1111;
    load_data  = '0;
    shifted    = rdata >> {addr_lo, 3'b000};
    misaligned = lsu_misaligned(width, addr_lo);

    case (width)
      LSW_BYTE: begin
        wdata     = {4{store_data[7:0]}};
        byte_en   = 4'b0001 << addr_lo;
        load_data = uns ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      LSW_HALF: begin
        wdata     = {2{store_data[15:0]}};
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        load_data = uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        wdata     = store_data;
        byte_en   = 4'b1111;
        load_data = shifted;
      end
    endcase

    // Loads always fetch the whole word; lane selection happens on return.
    if (is_load) byte_en = 4'b1111;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request/grant/response bus transaction
// per access, holding the pipeline busy until writeback or store completion.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_Valid_1,
  input  logic        i_Load_1,
  input  logic        i_Store_1,
  input  logic        i_LoadUnsigned_1,
  input  logic [1:0]  i_LoadStoreWidth_2,
  input  logic [31:0] i_Addr_32,
  input  logic [31:0] i_StoreData_32,
  input  logic [4:0]  i_RdAddr_5,
  output logic        o_Busy_1,
  output logic        o_MemReq_1,
  output logic        o_MemWe_1,
  output logic [31:0] o_MemAddr_32,
  output logic [31:0] o_MemWdata_32,
  output logic [3:0]  o_MemByteEn_4,
  input  logic        i_MemGnt_1,
  input  logic        i_MemRvalid_1,
  input  logic [31:0] i_MemRdata_32,
  output logic        o_WbValid_1,
  output logic [4:0]  o_WbAddr_5,
  output logic [31:0] o_WbData_32,
  output logic        o_StoreDone_1,
  output logic        o_Misaligned_1,
  output logic [1:0]  o_DbgState_2
);

  // Bus handshake: o_MemReq_1 with address/we/wdata/byte-enable is held
  // stable until the cycle i_MemGnt_1 is high; i_MemRvalid_1 is only
  // honoured in RESP and i_MemGnt_1 only in REQ.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_e;

  state_e      state_q, state_d;
  lsu_req_t    req_q;
  logic [31:0] mem_addr_q, wdata_q, wb_data_q;
  logic [3:0]  be_q;

  logic        in_idle, accept;
  logic        al_is_load, al_uns, al_misaligned;
  logic [1:0]  al_width, al_addr_lo;
  logic [31:0] al_wdata, al_load_data;
  logic [3:0]  al_be;

  assign in_idle = (state_q == S_IDLE);
  assign accept  = in_idle & i_Valid_1 & (i_Load_1 | i_Store_1);

  // In IDLE the aligner sees the incoming access; afterwards the captured one.
  assign al_is_load = in_idle ? i_Load_1           : req_q.is_load;
  assign al_uns     = in_idle ? i_LoadUnsigned_1   : req_q.uns;
  assign al_width   = in_idle ? i_LoadStoreWidth_2 : req_q.width;
  assign al_addr_lo = in_idle ? i_Addr_32[1:0]     : req_q.addr_lo;

  lsu_align u_align (
    .is_load    (al_is_load),
    .width      (al_width),
    .addr_lo    (al_addr_lo),
    .uns        (al_uns),
    .store_data (i_StoreData_32),
    .rdata      (i_MemRdata_32),
    .wdata      (al_wdata),
    .byte_en    (al_be),
    .load_data  (al_load_data),
    .misaligned (al_misaligned)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = al_misaligned ? S_DONE : S_REQ;
      S_REQ:  if (i_MemGnt_1) state_d = req_q.is_load ? S_RESP : S_DONE;
      S_RESP: if (i_MemRvalid_1) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q.is_load <= i_Load_1;
        req_q.uns     <= i_LoadUnsigned_1;
        req_q.width   <= i_LoadStoreWidth_2;
        req_q.addr_lo <= i_Addr_32[1:0];
        req_q.rd      <= i_RdAddr_5;
        req_q.err     <= al_misaligned;
        // A rejected access leaves the bus-facing registers untouched.
        if (!al_misaligned) begin
          mem_addr_q <= {i_Addr_32[31:2], 2'b00};
          wdata_q    <= al_wdata;
          be_q       <= al_be;
        end
      end
      if (state_q == S_RESP && i_MemRvalid_1) wb_data_q <= al_load_data;
    end
  end

  assign o_Busy_1       = ~in_idle;
  assign o_MemReq_1     = (state_q == S_REQ);
  assign o_MemWe_1      = (state_q == S_REQ) & ~req_q.is_load;
  assign o_MemAddr_32   = mem_addr_q;
  assign o_MemWdata_32  = wdata_q;
  assign o_MemByteEn_4  = be_q;
  assign o_WbValid_1    = (state_q == S_DONE) &  req_q.is_load & ~req_q.err;
  assign o_StoreDone_1  = (state_q == S_DONE) & ~req_q.is_load & ~req_q.err;
  assign o_Misaligned_1 = (state_q == S_DONE) &  req_q.err;
  assign o_WbAddr_5     = req_q.rd;
  assign o_WbData_32    = wb_data_q;
  assign o_DbgState_2   = state_q;

endmodule
